// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake, operands and result flags of the bit-serial adder.
// master drives the request side; slave (the adder) drives the result side.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output start, sub, a, b, c_in,
      input  busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, sub, a, b, c_in,
      output busy, done, sum, c_out, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit add/subtract, one full-adder slice and a carry flop, LSB first.
// Define SERIAL_ADDER_SUB_EN to honour bus.sub; otherwise sub is ignored and only add is built.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sr_a, sr_a_next;
   logic [WIDTH-1:0] sr_b, sr_b_next;
   logic [WIDTH-1:0] res, res_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             carry, carry_next;
   logic             sub_q, sub_next;
   logic [WIDTH-1:0] sum_q, sum_next;
   logic             c_out_q, c_out_next;
   logic             ovf_q, ovf_next;
   logic             busy_q, busy_next;
   logic             done_q, done_next;

   // Operand conditioning at accept time: subtract is a + ~b + 1 with borrow-in folded into carry.
   logic             op_sub;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign op_sub     = bus.sub;
   assign b_load     = bus.b ^ {WIDTH{bus.sub}};
   assign carry_load = bus.c_in ^ bus.sub;
`else
   logic unused_sub;
   assign unused_sub = bus.sub;
   assign op_sub     = 1'b0;
   assign b_load     = bus.b;
   assign carry_load = bus.c_in;
`endif

   // Single full-adder slice on the current LSBs.
   logic             bit_sum;
   logic             bit_carry;
   logic [WIDTH-1:0] res_shift;

   assign bit_sum   = sr_a[0] ^ sr_b[0] ^ carry;
   assign bit_carry = (sr_a[0] & sr_b[0]) | (sr_a[0] & carry) | (sr_b[0] & carry);
   assign res_shift = (res >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sr_a    <= '0;
         sr_b    <= '0;
         res     <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_next;
         sr_a    <= sr_a_next;
         sr_b    <= sr_b_next;
         res     <= res_next;
         cnt     <= cnt_next;
         carry   <= carry_next;
         sub_q   <= sub_next;
         sum_q   <= sum_next;
         c_out_q <= c_out_next;
         ovf_q   <= ovf_next;
         busy_q  <= busy_next;
         done_q  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      sr_a_next  = sr_a;
      sr_b_next  = sr_b;
      res_next   = res;
      cnt_next   = cnt;
      carry_next = carry;
      sub_next   = sub_q;
      sum_next   = sum_q;
      c_out_next = c_out_q;
      ovf_next   = ovf_q;
      busy_next  = 1'b0;
      done_next  = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               sr_a_next  = bus.a;
               sr_b_next  = b_load;
               carry_next = carry_load;
               sub_next   = op_sub;
               cnt_next   = '0;
               state_next = RUN;
               busy_next  = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            sr_a_next  = sr_a >> 1;
            sr_b_next  = sr_b >> 1;
            carry_next = bit_carry;
            res_next   = res_shift;
            cnt_next   = cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
               // carry is the carry into the MSB, bit_carry the carry out of it
               sum_next   = res_shift;
               c_out_next = bit_carry ^ sub_q;
               ovf_next   = carry ^ bit_carry;
               done_next  = 1'b1;
               state_next = DONE;
            end else begin
               busy_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for WIDTH=1 and WIDTH=8 instances; expected results queued at
// accept time and checked by per-instance monitors whenever done is seen.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1;
   logic rst8;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   serial_adder_if #(.WIDTH(1)) bus1 ();
   serial_adder_if #(.WIDTH(8)) bus8 ();

   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

   typedef struct {
      logic [7:0]  sum;
      logic        c_out;
      logic        ovf;
      int unsigned acc;
      string       name;
   } exp_t;

   exp_t        q1[$];
   exp_t        q8[$];
   exp_t        e1;
   exp_t        e8;
   int unsigned done8_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: every done must match the oldest queued expectation, including its latency.
   always @(negedge clk) begin
      if (bus1.done) begin
         if (q1.size() == 0) chk("w1 unexpected done", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk({e1.name, " sum"},     32'(bus1.sum),   32'(e1.sum));
            chk({e1.name, " c_out"},   32'(bus1.c_out), 32'(e1.c_out));
            chk({e1.name, " ovf"},     32'(bus1.ovf),   32'(e1.ovf));
            chk({e1.name, " latency"}, cyc - e1.acc,    32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (bus8.done) begin
         done8_log.push_back(cyc);
         if (q8.size() == 0) chk("w8 unexpected done", 32'd1, 32'd0);
         else begin
            e8 = q8.pop_front();
            chk({e8.name, " sum"},     32'(bus8.sum),   32'(e8.sum));
            chk({e8.name, " c_out"},   32'(bus8.c_out), 32'(e8.c_out));
            chk({e8.name, " ovf"},     32'(bus8.ovf),   32'(e8.ovf));
            chk({e8.name, " latency"}, cyc - e8.acc,    32'd8);
         end
      end
   end

   task automatic drain1(input string name);
      int n = 0;
      while (q1.size() != 0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (q1.size() != 0) begin
         chk({name, " timeout"}, 32'(q1.size()), 32'd0);
         q1.delete();
      end
   endtask

   task automatic drain8(input string name);
      int n = 0;
      while (q8.size() != 0 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (q8.size() != 0) begin
         chk({name, " timeout"}, 32'(q8.size()), 32'd0);
         q8.delete();
      end
   endtask

   task automatic issue1(input logic c_in, input logic a, input logic b,
                         input logic es, input logic ec, input logic eo, input string name);
      exp_t e;
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.c_in = c_in; bus1.sub = 1'b0;
      @(posedge clk); #1;
      e = '{8'(es), ec, eo, cyc, name};
      q1.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.c_in = ~c_in;
      chk({name, " busy"}, 32'(bus1.busy), 32'd1);
      drain1(name);
   endtask

   // Operands are scrambled right after accept; poke also fires a stray start mid-RUN.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic c_in,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input bit poke, input string name);
      exp_t e;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.c_in = c_in;
      @(posedge clk); #1;
      e = '{es, ec, eo, cyc, name};
      q8.push_back(e);
      @(negedge clk);
      bus8.start = 1'b0; bus8.a = ~a; bus8.b = 8'h5A; bus8.sub = ~sub; bus8.c_in = ~c_in;
      chk({name, " busy"}, 32'(bus8.busy), 32'd1);
      if (poke) begin
         repeat (2) @(negedge clk);
         bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'hC1;
         @(negedge clk);
         bus8.start = 1'b0;
      end
      drain8(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst1 = 1'b1; rst8 = 1'b1;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.c_in = 1'b0;
      bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1'b0; bus8.c_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("w8 reset busy",  32'(bus8.busy),  32'd0);
      chk("w8 reset done",  32'(bus8.done),  32'd0);
      chk("w8 reset sum",   32'(bus8.sum),   32'd0);
      chk("w8 reset c_out", 32'(bus8.c_out), 32'd0);
      chk("w8 reset ovf",   32'(bus8.ovf),   32'd0);
      chk("w1 reset busy",  32'(bus1.busy),  32'd0);
      chk("w1 reset sum",   32'(bus1.sum),   32'd0);
      bus8.start = 1'b0;
      rst1 = 1'b0; rst8 = 1'b0;

      // WIDTH=1 full-adder truth table, {c_in,a,b}; ovf = c_in ^ c_out
      issue1(0, 0, 0, 0, 0, 0, "fa000");
      issue1(0, 0, 1, 1, 0, 0, "fa001");
      issue1(0, 1, 0, 1, 0, 0, "fa010");
      issue1(0, 1, 1, 0, 1, 1, "fa011");
      issue1(1, 0, 0, 1, 0, 1, "fa100");
      issue1(1, 0, 1, 0, 1, 0, "fa101");
      issue1(1, 1, 0, 0, 1, 0, "fa110");
      issue1(1, 1, 1, 1, 1, 0, "fa111");

      // WIDTH=8 additions
      issue8(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1'b1, "add 0F+01");
      issue8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1'b0, "add FF+01");
      issue8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1'b1, "add 7F+01");
      issue8(8'hFF, 8'h00, 0, 1, 8'h00, 1, 0, 1'b0, "add FF+00+1");

`ifdef SERIAL_ADDER_SUB_EN
      issue8(8'h05, 8'h07, 1, 0, 8'hFE, 1, 0, 1'b0, "sub 05-07");
      issue8(8'h80, 8'h01, 1, 0, 8'h7F, 0, 1, 1'b1, "sub 80-01");
      issue8(8'h10, 8'h05, 1, 1, 8'h0A, 0, 0, 1'b0, "sub 10-05-1");
`else
      issue8(8'h05, 8'h07, 1, 0, 8'h0C, 0, 0, 1'b0, "nosub 05,07");
      issue8(8'h80, 8'h01, 1, 0, 8'h81, 0, 0, 1'b1, "nosub 80,01");
      issue8(8'h10, 8'h05, 1, 1, 8'h16, 0, 0, 1'b0, "nosub 10,05,1");
`endif

      // Start held high across three operations, operands changed mid-RUN
      base = done8_log.size();
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.sub = 1'b0; bus8.c_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         @(posedge clk); #1;
         e = '{8'(2 * (i + 1)), 1'b0, 1'b0, cyc, "b2b"};
         q8.push_back(e);
         @(negedge clk);
         if (i < 2) begin
            bus8.a = 8'(i + 2); bus8.b = 8'(i + 2);
            repeat (8) @(posedge clk);
         end else begin
            bus8.start = 1'b0; bus8.a = 8'hE7; bus8.b = 8'h9C; bus8.c_in = 1'b1;
         end
      end
      drain8("b2b");
      chk("b2b done count", 32'(done8_log.size() - base), 32'd3);
      if (done8_log.size() >= base + 3) begin
         chk("b2b spacing 1", done8_log[base + 1] - done8_log[base],     32'd9);
         chk("b2b spacing 2", done8_log[base + 2] - done8_log[base + 1], 32'd9);
      end

      // Leave nonzero flags so the reset below has something to clear
      issue8(8'h80, 8'hFF, 0, 0, 8'h7F, 1, 1, 1'b0, "add 80+FF");

      // Abort a RUN with reset (start also high on the reset edge)
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b0; bus8.c_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst8 = 1'b1; bus8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0; bus8.start = 1'b0;
      chk("abort busy",  32'(bus8.busy),  32'd0);
      chk("abort done",  32'(bus8.done),  32'd0);
      chk("abort sum",   32'(bus8.sum),   32'd0);
      chk("abort c_out", 32'(bus8.c_out), 32'd0);
      chk("abort ovf",   32'(bus8.ovf),   32'd0);
      base = done8_log.size();
      repeat (10) @(negedge clk);
      chk("abort no done", 32'(done8_log.size() - base), 32'd0);
      issue8(8'hAA, 8'h55, 0, 0, 8'hFF, 0, 0, 1'b0, "add AA+55");

      repeat (3) @(negedge clk);
      chk("w8 queue empty", 32'(q8.size()), 32'd0);
      chk("w1 queue empty", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
